// File: rtl/strobe_meter_pkg.sv
// strobe_meter_pkg: shared definitions for the strobe period meter.
//   state_t : FSM state encoding (IDLE = 0, ARMED = 1)
`ifndef STROBE_METER_PKG_SV
`define STROBE_METER_PKG_SV

package strobe_meter_pkg;

    typedef enum logic [0:0] {
        STROBE_METER_IDLE  = 1'b0,
        STROBE_METER_ARMED = 1'b1
    } state_t;

endpackage

`endif

// File: rtl/strobe_meter_interval_counter.sv
// interval_counter: W-bit saturating up-counter with synchronous load-to-1.
// Ports:
//   clock    : system clock
//   reset    : synchronous, active-high reset (cnt = 0)
//   load     : load cnt with 1 (takes priority over inc)
//   inc      : increment cnt; holds at all-ones
//   cnt      : current count
//   terminal : high when cnt is all-ones
module interval_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         load,
    input  logic         inc,
    output logic [W-1:0] cnt,
    output logic         terminal
);

    assign terminal = &cnt;

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= {{(W-1){1'b0}}, 1'b1};
        end else if (inc && !terminal) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/strobe_meter.sv
// strobe_meter: measures the interval in clock cycles between successive
// events on act and reports each measured period.
// Ports:
//   clock  : system clock
//   reset  : synchronous, active-high reset
//   act    : event input
//   period : last measured interval (held between measurements)
//   valid  : one-cycle pulse, period just updated
//   locked : high while the last two measurements are equal
//   over   : one-cycle pulse, interval exceeded 2^W-1 and was abandoned
// Build option: STROBE_METER_EDGE_EN - when defined only rising edges of act
// count as events; otherwise every high cycle of act is an event.
module strobe_meter
    import strobe_meter_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         act,
    output logic [W-1:0] period,
    output logic         valid,
    output logic         locked,
    output logic         over
);

    state_t       state;
    logic         have;
    logic         evt;
    logic [W-1:0] cnt;
    logic         terminal;

`ifdef STROBE_METER_EDGE_EN
    logic act_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            act_q <= 1'b0;
        end else begin
            act_q <= act;
        end
    end

    assign evt = act & ~act_q;
`else
    assign evt = act;
`endif

    // Every event restarts the interval at 1; counting only runs while armed.
    interval_counter #(.W(W)) u_cnt (
        .clock    (clock),
        .reset    (reset),
        .load     (evt),
        .inc      (state == STROBE_METER_ARMED),
        .cnt      (cnt),
        .terminal (terminal)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= STROBE_METER_IDLE;
            period <= '0;
            valid  <= 1'b0;
            locked <= 1'b0;
            over   <= 1'b0;
            have   <= 1'b0;
        end else begin
            valid <= 1'b0;
            over  <= 1'b0;
            case (state)
                STROBE_METER_IDLE: begin
                    locked <= 1'b0;
                    if (evt) begin
                        have  <= 1'b0;
                        state <= STROBE_METER_ARMED;
                    end
                end
                STROBE_METER_ARMED: begin
                    if (evt) begin
                        // An event at all-ones is still a valid measurement.
                        period <= cnt;
                        valid  <= 1'b1;
                        have   <= 1'b1;
                        locked <= have && (cnt == period);
                    end else if (terminal) begin
                        over   <= 1'b1;
                        locked <= 1'b0;
                        state  <= STROBE_METER_IDLE;
                    end
                end
                default: state <= STROBE_METER_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_strobe_meter.sv
// tb_strobe_meter: directed self-checking bench for strobe_meter (W = 8).
module tb_strobe_meter;

    logic       clock;
    logic       reset;
    logic       act;
    logic [7:0] period;
    logic       valid;
    logic       locked;
    logic       over;

    int n_tests = 0;
    int n_fail  = 0;

    strobe_meter #(.W(8)) dut (
        .clock  (clock),
        .reset  (reset),
        .act    (act),
        .period (period),
        .valid  (valid),
        .locked (locked),
        .over   (over)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One clock cycle with act driven to a; outputs sampled 1 time unit
    // after the edge, so they reflect what happened in this cycle.
    task automatic tick(input logic a);
        act = a;
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(1'b0);
        reset = 1'b0;
    endtask

    // Event, then n-1 quiet cycles: the next event lands n cycles later.
    task automatic pulse_gap(input int n);
        tick(1'b1);
        idle(n - 1);
    endtask

    initial begin
        reset = 1'b1;
        act   = 1'b0;
        @(posedge clock);
        #1;
        // event during reset is ignored
        tick(1'b1);
        reset = 1'b0;
        check("rst_period", period, 0);
        check("rst_valid",  valid,  0);
        check("rst_locked", locked, 0);
        check("rst_over",   over,   0);
        idle(3);
        check("rst_no_arm_valid", valid, 0);

        // Test 1: intervals of 5
        tick(1'b1);
        check("t1_first_valid", valid, 0);
        idle(4);
        tick(1'b1);
        check("t1_m1_valid",  valid,  1);
        check("t1_m1_period", period, 5);
        check("t1_m1_locked", locked, 0);
        tick(1'b0);
        check("t1_valid_pulse", valid, 0);
        check("t1_hold_period", period, 5);
        idle(3);
        tick(1'b1);
        check("t1_m2_period", period, 5);
        check("t1_m2_locked", locked, 1);
        idle(4);
        tick(1'b1);
        check("t1_m3_locked", locked, 1);

        // Test 2: change to 7 breaks lock, repeat restores it
        idle(6);
        tick(1'b1);
        check("t2_period7", period, 7);
        check("t2_unlock",  locked, 0);
        idle(6);
        tick(1'b1);
        check("t2_relock", locked, 1);

`ifndef STROBE_METER_EDGE_EN
        // Test 3: act held high
        do_reset();
        tick(1'b1);
        check("t3_e1_valid", valid, 0);
        tick(1'b1);
        check("t3_e2_valid",  valid,  1);
        check("t3_e2_period", period, 1);
        check("t3_e2_locked", locked, 0);
        tick(1'b1);
        check("t3_e3_valid",  valid,  1);
        check("t3_e3_locked", locked, 1);
        tick(1'b1);
        check("t3_e4_valid",  valid,  1);
        check("t3_e4_locked", locked, 1);
        tick(1'b0);
`endif

        // Test 4: maximum interval and overflow
        do_reset();
        pulse_gap(255);
        tick(1'b1);
        check("t4_max_valid",  valid,  1);
        check("t4_max_period", period, 255);
        check("t4_max_over",   over,   0);
        idle(254);
        check("t4_pre_over", over, 0);
        tick(1'b0);
        check("t4_over",        over,   1);
        check("t4_over_valid",  valid,  0);
        check("t4_over_period", period, 255);
        check("t4_over_locked", locked, 0);
        tick(1'b0);
        check("t4_over_pulse", over, 0);
        idle(3);
        tick(1'b1);
        check("t4_rearm_valid", valid, 0);
        idle(3);
        check("t4_rearm_quiet", valid, 0);
        tick(1'b1);
        check("t4_after_rearm_period", period, 4);
        check("t4_after_rearm_locked", locked, 0);
        tick(1'b0);

        // Test 5: reset mid-interval while locked
        do_reset();
        pulse_gap(5);
        pulse_gap(5);
        tick(1'b1);
        check("t5_locked", locked, 1);
        idle(2);
        do_reset();
        check("t5_rst_period", period, 0);
        check("t5_rst_valid",  valid,  0);
        check("t5_rst_locked", locked, 0);
        check("t5_rst_over",   over,   0);
        tick(1'b1);
        check("t5_e1_valid", valid, 0);
        idle(4);
        tick(1'b1);
        check("t5_e2_valid",  valid,  1);
        check("t5_e2_period", period, 5);
        check("t5_e2_locked", locked, 0);
        tick(1'b0);

        // Test 6: act high 3 cycles every 10
        do_reset();
        for (int i = 0; i < 40; i++) begin
            tick((i % 10) < 3);
`ifdef STROBE_METER_EDGE_EN
            if (i == 10) begin
                check("t6e_p1",     period, 10);
                check("t6e_p1_lck", locked, 0);
            end
            if (i == 20) begin
                check("t6e_p2",     period, 10);
                check("t6e_p2_lck", locked, 1);
            end
            if (i == 21) check("t6e_one_meas", valid, 0);
`else
            if (i == 1)  check("t6_p_a", period, 1);
            if (i == 2)  check("t6_p_b", period, 1);
            if (i == 10) begin
                check("t6_p_c",     period, 8);
                check("t6_p_c_lck", locked, 0);
            end
            if (i == 11) check("t6_p_d", period, 1);
            if (i == 20) check("t6_p_e", period, 8);
`endif
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
